// File: rtl/tetris_piece_ctl_if.sv
// Pose-check handshake between the piece controller (master) and the board collision checker (slave).
interface tetris_piece_ctl_if #(
  parameter int unsigned XW = 5,
  parameter int unsigned YW = 5
);
  logic          chk_req;
  logic [XW-1:0] chk_x;
  logic [YW-1:0] chk_y;
  logic [1:0]    chk_rot;
  logic          chk_valid;
  logic          chk_ok;

  modport master (output chk_req, chk_x, chk_y, chk_rot, input chk_valid, chk_ok);
  modport slave  (input chk_req, chk_x, chk_y, chk_rot, output chk_valid, chk_ok);
endinterface

// File: rtl/tetris_piece_ctl.sv
// Active falling-piece controller: gravity, button moves/rotations with wall kicks, pose checks, lock/respawn.
// Optional held-button auto-repeat for left/right is enabled by defining TETRIS_AUTOREPEAT_EN.
module tetris_piece_ctl #(
  parameter int unsigned COLS         = 10,
  parameter int unsigned ROWS         = 20,
  parameter int unsigned XW           = 5,
  parameter int unsigned YW           = 5,
  parameter int unsigned NUM_BLOCKS   = 7,
  parameter int unsigned TICK_DIV     = 65536,
  parameter int unsigned FALL_BASE    = 1000,
  parameter int unsigned FALL_STEP    = 100,
  parameter int unsigned REPEAT_TICKS = 150
) (
  input  logic                      pclk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [3:0]                level,
  input  logic                      btnL,
  input  logic                      btnR,
  input  logic                      btnD,
  input  logic                      btnU,
  tetris_piece_ctl_if.master        chk,
  output logic [XW-1:0]             xpos,
  output logic [YW-1:0]             ypos,
  output logic [2:0]                block,
  output logic [1:0]                rot,
  output logic                      lock,
  output logic                      game_over
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PW = (FALL_BASE > 1) ? $clog2(FALL_BASE + 1) : 1;
  localparam int unsigned RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
  localparam logic [XW-1:0] X_SPAWN  = XW'(COLS / 2 - 1);
  localparam logic [XW-1:0] X_MAX    = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_MAX    = YW'(ROWS - 1);
  localparam logic [2:0]    BLK_LAST = 3'(NUM_BLOCKS - 1);

`ifdef TETRIS_AUTOREPEAT_EN
  localparam bit AR_EN = 1'b1;
`else
  localparam bit AR_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    WAIT_START, SPAWN, SPAWN_CHK, IDLE, CHECK, KICK_L, KICK_R, LOCK, GAME_OVER
  } state_t;

  typedef enum logic [2:0] {
    OP_DOWN, OP_ROT, OP_RIGHT, OP_LEFT, OP_KICK_L, OP_KICK_R
  } op_t;

  state_t        state_q, state_n;
  op_t           op_q, op_n;
  logic [XW-1:0] xpos_n, cx_q, cx_n;
  logic [YW-1:0] ypos_n, cy_q, cy_n;
  logic [1:0]    rot_n, crot_q, crot_n;
  logic [2:0]    block_n;
  logic          lock_n, go_n, req_q, req_n;
  logic [3:0]    lvl_q, lvl_n;
  logic          pend_q, pend_n;
  logic [3:0]    btn_q, btn_edge;
  logic [TW-1:0] tick_cnt_q;
  logic [PW-1:0] per_cnt_q, period;
  logic [RW-1:0] rep_cnt_q;
  logic [31:0]   dec;
  logic          tick, expire, grav_clr, rep_fire, take_down, edge_l, edge_r;

  assign chk.chk_req = req_q;
  assign chk.chk_x   = cx_q;
  assign chk.chk_y   = cy_q;
  assign chk.chk_rot = crot_q;

  // Gravity period in ticks, floored at one tick for high levels
  always_comb begin
    dec    = 32'(FALL_STEP) * 32'(lvl_q);
    period = (dec >= 32'(FALL_BASE)) ? PW'(1) : PW'(32'(FALL_BASE) - dec);
    tick   = (tick_cnt_q == TW'(TICK_DIV - 1));
    expire = tick && ((per_cnt_q + PW'(1)) == period);
  end

  always_ff @(posedge pclk) begin
    if (!rst || grav_clr) begin
      tick_cnt_q <= '0;
      per_cnt_q  <= '0;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
      if (tick) per_cnt_q <= expire ? '0 : per_cnt_q + PW'(1);
    end
  end

  // Button edges {D,U,R,L}; auto-repeat folds into the left/right edges
  assign btn_edge = {btnD, btnU, btnR, btnL} & ~btn_q;
  assign rep_fire = AR_EN && (btnL || btnR) && tick && (rep_cnt_q == RW'(REPEAT_TICKS - 1));
  assign edge_r   = btn_edge[1] || (rep_fire && btnR);
  assign edge_l   = btn_edge[0] || (rep_fire && btnL && !btnR);

  always_ff @(posedge pclk) begin
    if (!rst || !AR_EN || !(btnL || btnR) || btn_edge[0] || btn_edge[1]) rep_cnt_q <= '0;
    else if (tick) rep_cnt_q <= rep_fire ? '0 : rep_cnt_q + RW'(1);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_n   = state_q;
    op_n      = op_q;
    xpos_n    = xpos;
    ypos_n    = ypos;
    rot_n     = rot;
    block_n   = block;
    lock_n    = 1'b0;
    go_n      = game_over;
    req_n     = req_q;
    cx_n      = cx_q;
    cy_n      = cy_q;
    crot_n    = crot_q;
    lvl_n     = lvl_q;
    pend_n    = pend_q || expire;
    grav_clr  = 1'b0;
    take_down = pend_q || expire || btn_edge[3];

    case (state_q)
      WAIT_START: if (start) state_n = SPAWN;
      SPAWN: begin
        xpos_n   = X_SPAWN;
        ypos_n   = '0;
        rot_n    = '0;
        lvl_n    = level;
        grav_clr = 1'b1;
        pend_n   = 1'b0;
        req_n    = 1'b1;
        cx_n     = X_SPAWN;
        cy_n     = '0;
        crot_n   = '0;
        state_n  = SPAWN_CHK;
      end
      SPAWN_CHK: begin
        if (chk.chk_valid) begin
          req_n = 1'b0;
          if (chk.chk_ok) state_n = IDLE;
          else begin
            go_n    = 1'b1;
            state_n = GAME_OVER;
          end
        end
      end
      IDLE: begin
        if (take_down) begin
          pend_n = 1'b0;
          if (ypos == Y_MAX) begin
            lock_n  = 1'b1;
            state_n = LOCK;
          end else begin
            req_n = 1'b1; cx_n = xpos; cy_n = ypos + YW'(1); crot_n = rot;
            op_n  = OP_DOWN; state_n = CHECK;
          end
        end else if (btn_edge[2]) begin
          req_n = 1'b1; cx_n = xpos; cy_n = ypos; crot_n = rot + 2'd1;
          op_n  = OP_ROT; state_n = CHECK;
        end else if (edge_r) begin
          if (xpos != X_MAX) begin
            req_n = 1'b1; cx_n = xpos + XW'(1); cy_n = ypos; crot_n = rot;
            op_n  = OP_RIGHT; state_n = CHECK;
          end
        end else if (edge_l) begin
          if (xpos != '0) begin
            req_n = 1'b1; cx_n = xpos - XW'(1); cy_n = ypos; crot_n = rot;
            op_n  = OP_LEFT; state_n = CHECK;
          end
        end
      end
      CHECK: begin
        if (chk.chk_valid) begin
          req_n = 1'b0;
          if (chk.chk_ok) begin
            xpos_n  = cx_q;
            ypos_n  = cy_q;
            rot_n   = crot_q;
            state_n = IDLE;
            if (op_q == OP_DOWN) begin
              grav_clr = 1'b1;
              pend_n   = 1'b0;
            end
          end else begin
            case (op_q)
              OP_DOWN: begin
                lock_n  = 1'b1;
                state_n = LOCK;
              end
              OP_ROT:    state_n = KICK_L;
              OP_KICK_L: state_n = KICK_R;
              default:   state_n = IDLE;
            endcase
          end
        end
      end
      // Kick retries keep the rotated candidate and shift x; a skipped kick falls through
      KICK_L: begin
        if (xpos != '0) begin
          req_n = 1'b1; cx_n = xpos - XW'(1); cy_n = ypos;
          op_n  = OP_KICK_L; state_n = CHECK;
        end else if (xpos != X_MAX) begin
          req_n = 1'b1; cx_n = xpos + XW'(1); cy_n = ypos;
          op_n  = OP_KICK_R; state_n = CHECK;
        end else state_n = IDLE;
      end
      KICK_R: begin
        if (xpos != X_MAX) begin
          req_n = 1'b1; cx_n = xpos + XW'(1); cy_n = ypos;
          op_n  = OP_KICK_R; state_n = CHECK;
        end else state_n = IDLE;
      end
      LOCK: begin
        block_n = (block == BLK_LAST) ? 3'd0 : block + 3'd1;
        state_n = SPAWN;
      end
      GAME_OVER: begin
        if (start) begin
          go_n    = 1'b0;
          block_n = 3'd0;
          state_n = SPAWN;
        end
      end
      default: state_n = WAIT_START;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      state_q   <= WAIT_START;
      op_q      <= OP_DOWN;
      xpos      <= X_SPAWN;
      ypos      <= '0;
      rot       <= '0;
      block     <= '0;
      lock      <= 1'b0;
      game_over <= 1'b0;
      req_q     <= 1'b0;
      cx_q      <= '0;
      cy_q      <= '0;
      crot_q    <= '0;
      lvl_q     <= '0;
      pend_q    <= 1'b0;
      btn_q     <= '0;
    end else begin
      state_q   <= state_n;
      op_q      <= op_n;
      xpos      <= xpos_n;
      ypos      <= ypos_n;
      rot       <= rot_n;
      block     <= block_n;
      lock      <= lock_n;
      game_over <= go_n;
      req_q     <= req_n;
      cx_q      <= cx_n;
      cy_q      <= cy_n;
      crot_q    <= crot_n;
      lvl_q     <= lvl_n;
      pend_q    <= pend_n;
      btn_q     <= {btnD, btnU, btnR, btnL};
    end
  end

endmodule

// File: tb/tb_tetris_piece_ctl.sv
// Directed bench for tetris_piece_ctl: scripted collision checker plus hand-computed pose/lock expectations.
module tb_tetris_piece_ctl;

  logic       pclk, rst, start;
  logic [3:0] level;
  logic       btnL, btnR, btnD, btnU;
  logic [4:0] xpos, ypos;
  logic [2:0] block;
  logic [1:0] rot;
  logic       lock, game_over;

  int n_tests = 0;
  int n_fail  = 0;

  // Checker model knobs and observations
  int         lat      = 1;
  int         fail_cnt = 0;
  logic       ok_val   = 1'b1;
  int         n_resp   = 0;
  int         wait_cnt = 0;
  logic [4:0] last_x, last_y;
  logic [1:0] last_rot;
  int         base;

  tetris_piece_ctl_if #(.XW(5), .YW(5)) ifc ();

  tetris_piece_ctl #(
    .COLS(10), .ROWS(20), .XW(5), .YW(5), .NUM_BLOCKS(7), .TICK_DIV(4),
    .FALL_BASE(1000), .FALL_STEP(100), .REPEAT_TICKS(150)
  ) dut (
    .pclk(pclk), .rst(rst), .start(start), .level(level),
    .btnL(btnL), .btnR(btnR), .btnD(btnD), .btnU(btnU),
    .chk(ifc),
    .xpos(xpos), .ypos(ypos), .block(block), .rot(rot),
    .lock(lock), .game_over(game_over)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Collision checker: answers each request after lat sampled cycles
  initial begin
    ifc.chk_valid = 1'b0;
    ifc.chk_ok    = 1'b0;
    forever begin
      @(negedge pclk);
      ifc.chk_valid = 1'b0;
      ifc.chk_ok    = 1'b0;
      if (ifc.chk_req === 1'b1) begin
        wait_cnt++;
        if (wait_cnt >= lat) begin
          ifc.chk_valid = 1'b1;
          ifc.chk_ok    = (fail_cnt > 0) ? 1'b0 : ok_val;
          if (fail_cnt > 0) fail_cnt--;
          last_x   = ifc.chk_x;
          last_y   = ifc.chk_y;
          last_rot = ifc.chk_rot;
          n_resp++;
          wait_cnt = 0;
        end
      end else wait_cnt = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btnL = v;
      1: btnR = v;
      2: btnD = v;
      default: btnU = v;
    endcase
  endtask

  // Press-and-release, then enough cycles for a full handshake with lat=1
  task automatic press(input int b);
    set_btn(b, 1'b1);
    repeat (2) @(negedge pclk);
    set_btn(b, 1'b0);
    repeat (6) @(negedge pclk);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; level = 4'd0;
    btnL = 1'b0; btnR = 1'b0; btnD = 1'b0; btnU = 1'b0;
    repeat (3) @(negedge pclk);
    check("rst_xpos", xpos, 4);
    check("rst_ypos", ypos, 0);
    check("rst_block", block, 0);
    check("rst_rot", rot, 0);
    check("rst_req", ifc.chk_req, 0);
    check("rst_chk_x", ifc.chk_x, 0);
    check("rst_lock", lock, 0);
    check("rst_game_over", game_over, 0);

    // Start: spawn check at (4,0,0)
    rst = 1'b1;
    @(negedge pclk);
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
    @(negedge pclk);
    check("spawn_req", ifc.chk_req, 1);
    check("spawn_x", ifc.chk_x, 4);
    check("spawn_y", ifc.chk_y, 0);
    check("spawn_rot", ifc.chk_rot, 0);
    repeat (3) @(negedge pclk);
    check("spawn_resp", n_resp, 1);
    check("spawn_req_low", ifc.chk_req, 0);
    check("spawn_game_over", game_over, 0);

    // Right moves up to the wall, then one rejected press
    for (int i = 0; i < 6; i++) begin
      press(1);
      check("right_xpos", xpos, 32'(5 + (i > 4 ? 4 : i)));
    end
    base = n_resp;
    press(1);
    check("right_wall_noreq", n_resp, base);
    check("right_wall_xpos", xpos, 9);
    check("right_ypos", ypos, 0);

    // Kick at left wall: rotate fails, KICK_L skipped, KICK_R (1,0,0) commits
    for (int i = 0; i < 9; i++) press(0);
    check("left_xpos", xpos, 0);
    for (int i = 0; i < 3; i++) press(3);
    check("rot3", rot, 3);
    base = n_resp;
    fail_cnt = 1;
    press(3);
    check("kick_reqs", n_resp, base + 2);
    check("kick_last_x", last_x, 1);
    check("kick_last_rot", last_rot, 0);
    check("kick_xpos", xpos, 1);
    check("kick_rot", rot, 0);

    // Slow checker: second left press during the wait is dropped
    press(1);
    press(1);
    check("pre_slow_xpos", xpos, 3);
    lat = 10;
    base = n_resp;
    btnL = 1'b1;
    repeat (2) @(negedge pclk);
    btnL = 1'b0;
    repeat (2) @(negedge pclk);
    btnL = 1'b1;
    repeat (2) @(negedge pclk);
    btnL = 1'b0;
    repeat (20) @(negedge pclk);
    check("slow_xpos", xpos, 2);
    check("slow_reqs", n_resp, base + 1);

    // Reset while a check is outstanding
    btnR = 1'b1;
    repeat (4) @(negedge pclk);
    btnR = 1'b0;
    check("midwait_req", ifc.chk_req, 1);
    rst = 1'b0;
    @(negedge pclk);
    check("midrst_req", ifc.chk_req, 0);
    check("midrst_xpos", xpos, 4);
    check("midrst_rot", rot, 0);
    check("midrst_chk_x", ifc.chk_x, 0);
    rst = 1'b1;
    lat = 1;
    repeat (15) @(negedge pclk);
    check("wait_start_idle_req", ifc.chk_req, 0);
    check("wait_start_xpos", xpos, 4);

    // Gravity at level 9: 100 ticks of 4 pclk per row
    level = 4'd9;
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
    @(negedge pclk);
    check("grav_spawn_req", ifc.chk_req, 1);
    repeat (398) @(negedge pclk);
    check("grav_before_drop", ypos, 0);
    repeat (6) @(negedge pclk);
    check("grav_first_drop", ypos, 1);
    for (int i = 0; i < 10000 && lock !== 1'b1; i++) @(negedge pclk);
    check("grav_lock_seen", lock, 1);
    check("grav_lock_ypos", ypos, 19);
    check("grav_lock_xpos", xpos, 4);
    check("grav_lock_block", block, 0);
    @(negedge pclk);
    check("grav_lock_pulse", lock, 0);
    check("grav_block_next", block, 1);
    @(negedge pclk);
    check("respawn_req", ifc.chk_req, 1);
    check("respawn_x", ifc.chk_x, 4);
    check("respawn_y", ifc.chk_y, 0);
    check("respawn_ypos", ypos, 0);
    repeat (3) @(negedge pclk);

    // Failing down check locks; then the respawn check fails -> game over
    fail_cnt = 2;
    btnD = 1'b1;
    for (int i = 0; i < 10 && lock !== 1'b1; i++) @(negedge pclk);
    btnD = 1'b0;
    check("down_fail_lock", lock, 1);
    check("down_fail_ypos", ypos, 0);
    @(negedge pclk);
    check("down_fail_block", block, 2);
    repeat (4) @(negedge pclk);
    check("game_over_set", game_over, 1);
    base = n_resp;
    press(1);
    press(3);
    check("game_over_noreq", n_resp, base);
    check("game_over_xpos", xpos, 4);
    check("game_over_held", game_over, 1);
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
    check("restart_block", block, 0);
    check("restart_game_over", game_over, 0);
    @(negedge pclk);
    check("restart_req", ifc.chk_req, 1);
    check("restart_x", ifc.chk_x, 4);
    repeat (3) @(negedge pclk);
    check("restart_ok", game_over, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
